iter_divider: RTL and testbench

- Parametrised multi-cycle RISC-V M-extension divide unit, instantiated in the EX stage. Replaces the fixed 32-bit divider wrapper.
- Supports DIV/DIVU/REM/REMU with selectable width and iterations per clock.
- Handles div-by-zero and signed overflow in one cycle.
- A last-result cache returns a DIV→REM (or REM→DIV) pair on identical operands in one cycle.
- Drives a stall to the pipeline while busy.

---
 rtl/iter_divider.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_iter_divider.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//
// Multi-cycle integer divide unit for the EX stage (RISC-V DIV/DIVU/REM/REMU).
// Division-by-zero and signed overflow are resolved in a single cycle. All
// other requests run a restoring shift-subtract loop that resolves
// ITER_PER_CYCLE quotient bits per clock. A one-entry last-result cache
// returns the partner result (REM after DIV, or DIV after REM) in one cycle
// when the operands and signedness match.
//
// Parameters:
//   WIDTH          operand/result width (>= 4, even)
//   ITER_PER_CYCLE quotient bits per clock (1, 2 or 4; divides WIDTH)
//   CACHE_EN       1 enables the last-result cache
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   start         request; held high with stable operands until result_valid
//   op            funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend      rs1 operand
//   divisor       rs2 operand
//   flush         synchronous abort of the in-flight op
//   result        quotient or remainder (registered, qualified by result_valid)
//   result_valid  one-cycle pulse in DONE
//   busy          high while iterating
//   stall         pipeline stall request (combinational)
// ---------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH          = 32,
  parameter int ITER_PER_CYCLE = 1,
  parameter bit CACHE_EN       = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             stall
);

  localparam int STEPS = WIDTH / ITER_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Control state (reset)
  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             valid_q,      valid_d;
  logic             cache_pend_q, cache_pend_d;
  logic             cache_vld_q,  cache_vld_d;

  // Datapath and cache payload (no reset; qualified by control state)
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic [WIDTH-1:0] dvs_mag_q,   dvs_mag_d;
  logic             neg_quo_q,   neg_quo_d;
  logic             neg_rem_q,   neg_rem_d;
  logic [1:0]       op_q,        op_d;
  logic [WIDTH-1:0] opa_q,       opa_d;
  logic [WIDTH-1:0] opb_q,       opb_d;
  logic [WIDTH-1:0] fin_quo_q,   fin_quo_d;
  logic [WIDTH-1:0] fin_rem_q,   fin_rem_d;
  logic [WIDTH-1:0] cache_dvd_q, cache_dvd_d;
  logic [WIDTH-1:0] cache_dvs_q, cache_dvs_d;
  logic             cache_sgn_q, cache_sgn_d;
  logic [WIDTH-1:0] cache_quo_q, cache_quo_d;
  logic [WIDTH-1:0] cache_rem_q, cache_rem_d;

  // Request classification
  logic             is_signed;
  logic             div_zero;
  logic             sgn_ovf;
  logic             cache_hit;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Iteration datapath
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  // -------------------------------------------------------------------------
  // Classification of the presented request (only meaningful in IDLE)
  // -------------------------------------------------------------------------
  always_comb begin
    is_signed = ~op[0];
    div_zero  = (divisor == '0);
    sgn_ovf   = is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES);
    cache_hit = CACHE_EN && cache_vld_q
             && (cache_dvd_q == dividend)
             && (cache_dvs_q == divisor)
             && (cache_sgn_q == is_signed);
    mag_a     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // -------------------------------------------------------------------------
  // Restoring shift-subtract, ITER_PER_CYCLE steps unrolled.
  // The dividend magnitude shifts out of quo from the MSB while quotient bits
  // shift in at the LSB, so one register serves both roles.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here chain the unrolled steps within one
    // cycle; each step sees the previous step's value, not the register.
    trial    = '0;
    step_rem = rem_q;
    step_quo = quo_q;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      trial    = {step_rem, step_quo[WIDTH-1]};
      step_quo = {step_quo[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs_mag_q}) begin
        trial       = trial - {1'b0, dvs_mag_q};
        step_quo[0] = 1'b1;
      end
      step_rem = trial[WIDTH-1:0];
    end
    // Quotient negates on differing signs; remainder follows the dividend.
    fix_quo = neg_quo_q ? -step_quo : step_quo;
    fix_rem = neg_rem_q ? -step_rem : step_rem;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default before the case so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    valid_d      = 1'b0;
    cache_pend_d = 1'b0;
    cache_vld_d  = cache_vld_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_mag_d    = dvs_mag_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    fin_quo_d    = fin_quo_q;
    fin_rem_d    = fin_rem_q;
    cache_dvd_d  = cache_dvd_q;
    cache_dvs_d  = cache_dvs_q;
    cache_sgn_d  = cache_sgn_q;
    cache_quo_d  = cache_quo_q;
    cache_rem_d  = cache_rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (div_zero) begin
            result_d = op[1] ? dividend : ALL_ONES;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else if (sgn_ovf) begin
            result_d = op[1] ? '0 : MIN_VAL;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else if (cache_hit) begin
            result_d = op[1] ? cache_rem_q : cache_quo_q;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = mag_a;
            dvs_mag_d = mag_b;
            neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = is_signed && dividend[WIDTH-1];
            op_d      = op;
            opa_d     = dividend;
            opb_d     = divisor;
            cnt_d     = CNT_LOAD;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            result_d     = op_q[1] ? fix_rem : fix_quo;
            valid_d      = 1'b1;
            fin_quo_d    = fix_quo;
            fin_rem_d    = fix_rem;
            cache_pend_d = 1'b1;
            state_d      = S_DONE;
          end
        end
      end

      S_DONE: begin
        // The cache is committed on leaving DONE so that a flush arriving in
        // the valid cycle still keeps the aborted result out of it.
        if (cache_pend_q && !flush) begin
          cache_vld_d = 1'b1;
          cache_dvd_d = opa_q;
          cache_dvs_d = opb_q;
          cache_sgn_d = ~op_q[0];
          cache_quo_d = fin_quo_q;
          cache_rem_d = fin_rem_q;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      result_q     <= '0;
      valid_q      <= 1'b0;
      cache_pend_q <= 1'b0;
      cache_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      cache_pend_q <= cache_pend_d;
      cache_vld_q  <= cache_vld_d;
    end
  end

  // NOTE: datapath and cache payload are deliberately left without reset;
  // they are only ever read under state_q/cache_vld_q, which are reset.
  always_ff @(posedge clk) begin
    rem_q       <= rem_d;
    quo_q       <= quo_d;
    dvs_mag_q   <= dvs_mag_d;
    neg_quo_q   <= neg_quo_d;
    neg_rem_q   <= neg_rem_d;
    op_q        <= op_d;
    opa_q       <= opa_d;
    opb_q       <= opb_d;
    fin_quo_q   <= fin_quo_d;
    fin_rem_q   <= fin_rem_d;
    cache_dvd_q <= cache_dvd_d;
    cache_dvs_q <= cache_dvs_d;
    cache_sgn_q <= cache_sgn_d;
    cache_quo_q <= cache_quo_d;
    cache_rem_q <= cache_rem_d;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign result       = result_q;
  // A flush in the DONE cycle withdraws the pulse for the aborted instruction.
  assign result_valid = valid_q & ~flush;
  assign busy         = (state_q == S_RUN);
  assign stall        = (state_q == S_RUN) | ((state_q == S_IDLE) & start & ~flush);

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//
// Three divider instances share op/operands/flush/reset but have private
// start lines: u_a (32 bit, 1 bit/clk, cache), u_b (16 bit, 4 bits/clk,
// cache), u_c (16 bit, 4 bits/clk, no cache). Only one instance is active at
// a time. The driver pushes the expected result and latency into a
// scoreboard queue; a monitor pops and compares on every result_valid.
// Expected values come from plain signed/unsigned integer division.
// ---------------------------------------------------------------------------
module tb_iter_divider;

  localparam int W_OF  [3] = '{32, 16, 16};
  localparam int STEPS [3] = '{32, 4, 4};
  localparam bit CEN   [3] = '{1'b1, 1'b1, 1'b0};

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    int          dut;
    logic [31:0] res;
    int          lat;
    int          issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        flush;
  logic [2:0]  start_v;
  logic [31:0] res_a;
  logic [15:0] res_b;
  logic [15:0] res_c;
  logic [2:0]  valid_v;
  logic [2:0]  busy_v;
  logic [2:0]  stall_v;
  logic [31:0] res_v [3];

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sbq [$];

  // Reference-model view of each instance's last-result cache
  bit          mc_valid [3];
  logic [31:0] mc_a     [3];
  logic [31:0] mc_b     [3];
  bit          mc_s     [3];

  iter_divider #(.WIDTH(32), .ITER_PER_CYCLE(1), .CACHE_EN(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op),
    .dividend(dvd), .divisor(dvs), .flush(flush),
    .result(res_a), .result_valid(valid_v[0]), .busy(busy_v[0]), .stall(stall_v[0])
  );

  iter_divider #(.WIDTH(16), .ITER_PER_CYCLE(4), .CACHE_EN(1'b1)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op),
    .dividend(dvd[15:0]), .divisor(dvs[15:0]), .flush(flush),
    .result(res_b), .result_valid(valid_v[1]), .busy(busy_v[1]), .stall(stall_v[1])
  );

  iter_divider #(.WIDTH(16), .ITER_PER_CYCLE(4), .CACHE_EN(1'b0)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .op(op),
    .dividend(dvd[15:0]), .divisor(dvs[15:0]), .flush(flush),
    .result(res_c), .result_valid(valid_v[2]), .busy(busy_v[2]), .stall(stall_v[2])
  );

  assign res_v[0] = res_a;
  assign res_v[1] = {16'b0, res_b};
  assign res_v[2] = {16'b0, res_c};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference: RISC-V division semantics with 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    longint ua, ub, sa, sb, q, r, m;
    m  = (longint'(1) << w) - 1;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    if (b == 0) begin
      q = m;
      r = ua;
    end else if (!o[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    q = q & m;
    r = r & m;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return (W_OF[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << W_OF[d]) - 32'd1);
  endfunction

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (valid_v[d]) begin
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          check($sformatf("unexpected_valid_dut%0d", d), 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check($sformatf("result_dut%0d", d), res_v[d], e.res);
          check($sformatf("latency_dut%0d", d), 32'(cyc - e.issue), 32'(e.lat));
        end
      end
    end
  end

  // Issue one op on instance d and wait for its result. Called and returns
  // 1 time unit after a rising edge.
  task automatic run_op(input int d, input logic [1:0] o,
                        input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] m, a, b;
    exp_t        e;
    bit          special, hit, seen;
    int          n_stall, n_busy;
    m       = mask_of(d);
    a       = a_in & m;
    b       = b_in & m;
    special = (b == 0) || (!o[0] && a == (32'd1 << (W_OF[d] - 1)) && b == m);
    hit     = CEN[d] && mc_valid[d] && mc_a[d] == a && mc_b[d] == b && mc_s[d] == !o[0];
    e.dut   = d;
    e.res   = ref_res(o, a, b, W_OF[d]);
    e.lat   = (special || hit) ? 1 : STEPS[d] + 1;
    e.issue = cyc;
    op  = o;
    dvd = a;
    dvs = b;
    start_v[d] = 1'b1;
    sbq.push_back(e);
    n_stall = 0;
    n_busy  = 0;
    seen    = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (valid_v[d]) begin
        seen = 1'b1;
        check("stall_in_done", 32'(stall_v[d]), 32'd0);
      end else begin
        n_stall += int'(stall_v[d]);
        n_busy  += int'(busy_v[d]);
      end
    end
    if (!seen) begin
      check($sformatf("timeout_dut%0d", d), 32'd0, 32'd1);
    end else begin
      check("stall_cycles", 32'(n_stall), 32'(e.lat));
      check("busy_cycles", 32'(n_busy), 32'(e.lat - 1));
    end
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    if (seen && !special && !hit && CEN[d]) begin
      mc_valid[d] = 1'b1;
      mc_a[d]     = a;
      mc_b[d]     = b;
      mc_s[d]     = !o[0];
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] ra, rb, la, lb, m;
    logic [1:0]  ro;

    reset   = 1'b1;
    flush   = 1'b0;
    start_v = '0;
    op      = OP_DIV;
    dvd     = '0;
    dvs     = '0;
    for (int d = 0; d < 3; d++) mc_valid[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", res_a, 32'd0);
    check("reset_valid", 32'(valid_v), 32'd0);
    check("reset_busy", 32'(busy_v), 32'd0);
    check("reset_stall", 32'(stall_v), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Iterative, then cache hit on the partner op
    run_op(0, OP_DIVU, 32'd100, 32'd7);
    run_op(0, OP_REMU, 32'd100, 32'd7);
    run_op(0, OP_DIV,  32'hFFFF_FFF9, 32'd2);
    run_op(0, OP_REM,  32'hFFFF_FFF9, 32'd2);
    run_op(0, OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    // Special cases
    run_op(0, OP_DIVU, 32'd5, 32'd0);
    run_op(0, OP_REM,  32'd5, 32'd0);
    run_op(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    // 16-bit, 4 bits per clock, with and without the cache
    run_op(1, OP_DIV, 32'h8000, 32'h0003);
    run_op(1, OP_REM, 32'h8000, 32'h0003);
    run_op(2, OP_DIV, 32'h8000, 32'h0003);
    run_op(2, OP_REM, 32'h8000, 32'h0003);

    // flush together with start in IDLE: request ignored
    op = OP_DIVU; dvd = 32'd1000; dvs = 32'd3;
    start_v[0] = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    check("stall_flush_idle", 32'(stall_v[0]), 32'd0);
    @(posedge clk);
    #1;
    check("busy_flush_idle", 32'(busy_v[0]), 32'd0);
    start_v[0] = 1'b0;
    flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // flush in the middle of RUN
    start_v[0] = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    flush      = 1'b1;
    start_v[0] = 1'b0;
    @(negedge clk);
    check("busy_before_flush", 32'(busy_v[0]), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("busy_after_flush", 32'(busy_v[0]), 32'd0);
    check("stall_after_flush", 32'(stall_v[0]), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op(0, OP_DIVU, 32'd1000, 32'd3);

    // Async reset between edges in RUN; cache must be invalidated
    run_op(0, OP_DIVU, 32'd100, 32'd7);
    op = OP_REMU; dvd = 32'd50; dvs = 32'd3;
    start_v[0] = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    start_v[0] = 1'b0;
    reset      = 1'b1;
    #1;
    check("busy_async_reset", 32'(busy_v[0]), 32'd0);
    check("stall_async_reset", 32'(stall_v[0]), 32'd0);
    check("valid_async_reset", 32'(valid_v[0]), 32'd0);
    check("result_async_reset", res_a, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) mc_valid[d] = 1'b0;
    @(posedge clk);
    #1;
    run_op(0, OP_REMU, 32'd100, 32'd7);

    // Randomised traffic with biased operand classes
    for (int d = 0; d < 3; d++) begin
      m  = mask_of(d);
      la = 32'd1;
      lb = 32'd1;
      for (int n = 0; n < 30; n++) begin
        ro = 2'($urandom_range(0, 3));
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 7))
          0:       rb = '0;
          1: begin ra = 32'd1 << (W_OF[d] - 1); rb = m; end
          2, 3: begin ra = la; rb = lb; end
          4:       rb = $urandom_range(1, 15);
          5:       rb = rb >> $urandom_range(0, W_OF[d] - 1);
          default: ;
        endcase
        run_op(d, ro, ra, rb);
        la = ra & m;
        lb = rb & m;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
